// File: rtl/packet_arbiter_pkg.sv
// packet_arbiter_pkg: state encoding and width helpers shared by the arbiter files
package packet_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FLUSH} state_t;
  function automatic int sbits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int lbits(input int m);
    return m > 0 ? $clog2(m + 1) : 1;
  endfunction
endpackage

// File: rtl/packet_arbiter_rr_pick.sv
// packet_arbiter_rr_pick: combinational round-robin picker, first requester after prev wins
module packet_arbiter_rr_pick
  import packet_arbiter_pkg::*;
#(
  parameter int NPORTS = 4,
  localparam int SBITS = sbits(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [SBITS-1:0]  prev,
  output logic [SBITS-1:0]  gnt,
  output logic              vld
);
  always_comb begin
    gnt = prev;
    vld = |req;
    // descending scan so the nearest port after prev is the final assignment
    for (int i = NPORTS; i >= 1; i--)
      if (req[(int'(prev) + i) % NPORTS]) gnt = SBITS'((int'(prev) + i) % NPORTS);
  end
endmodule

// File: rtl/packet_arbiter.sv
// packet_arbiter: round-robin packet-granular mux of N streams onto one packet_fifo write port,
// with a max-length watchdog that drops over-long packets and flushes their tail.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int WIDTH = 8,
  parameter int MAXLEN = 64,
  localparam int SBITS = sbits(NPORTS),
  localparam int LBITS = lbits(MAXLEN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       s_tvalid,
  output logic [NPORTS-1:0]       s_tready,
  input  logic [NPORTS-1:0]       s_tlast,
  input  logic [NPORTS-1:0]       s_tdrop,
  input  logic [NPORTS*WIDTH-1:0] s_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    m_tdrop,
  output logic [WIDTH-1:0]        m_tdata,
  output logic [SBITS-1:0]        grant_o,
  output logic                    trunc_o
);
  state_t state_q, state_d;
  logic [SBITS-1:0] grant_q, grant_d, pick_gnt;
  logic [LBITS-1:0] cnt_q, cnt_d;
  logic trunc_q, trunc_d, pick_vld, sv, sl, sd, wd, fire;

  packet_arbiter_rr_pick #(.NPORTS(NPORTS)) u_pick (
    .req(s_tvalid),
    .prev(grant_q),
    .gnt(pick_gnt),
    .vld(pick_vld)
  );

  always_comb begin
    sv = s_tvalid[grant_q];
    sl = s_tlast[grant_q];
    sd = s_tdrop[grant_q] && sv;
    wd = MAXLEN > 0 && int'(cnt_q) == MAXLEN - 1 && !sl;
    fire = sv && m_tready;
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tlast = 1'b0;
    m_tdrop = 1'b0;
    m_tdata = s_tdata[int'(grant_q)*WIDTH +: WIDTH];
    state_d = state_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    trunc_d = 1'b0;
    case (state_q)
      ST_IDLE: if (pick_vld) begin
        grant_d = pick_gnt;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        m_tvalid = sv;
        s_tready[grant_q] = m_tready;
        m_tlast = sl;
        m_tdrop = sd || (wd && sv);
        if (fire) begin
          cnt_d = int'(cnt_q) < MAXLEN ? cnt_q + 1'b1 : cnt_q;
          if (sl || sd) begin
            state_d = ST_IDLE;
            cnt_d = '0;
          end else if (wd) begin
            state_d = ST_FLUSH;
            cnt_d = '0;
            trunc_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        s_tready[grant_q] = 1'b1;
        if (sv && (sl || s_tdrop[grant_q])) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= SBITS'(NPORTS - 1);
      cnt_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      trunc_q <= trunc_d;
    end

  assign grant_o = grant_q;
  assign trunc_o = trunc_q;
endmodule

// File: tb/tb_packet_arbiter.sv
// tb_packet_arbiter: directed checks of grant order, backpressure, watchdog, drop and async reset
module tb_packet_arbiter;
  logic clk, rst;
  logic [3:0] s_tvalid, s_tready, s_tlast, s_tdrop;
  logic [31:0] s_tdata;
  logic m_tvalid, m_tready, m_tlast, m_tdrop, trunc_o;
  logic [7:0] m_tdata;
  logic [1:0] grant_o;
  int nchk, nerr, cyc_n, ntrunc;
  int rem[4], len[4], beat[4], pkt[4], drop_at[4];
  logic rdy;
  logic [7:0] log_d[$];
  logic log_l[$];
  int log_c[$];

  packet_arbiter #(.NPORTS(4), .WIDTH(8), .MAXLEN(4)) dut (
    .clock(clk), .reset(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdrop(s_tdrop), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdrop(m_tdrop), .m_tdata(m_tdata),
    .grant_o(grant_o), .trunc_o(trunc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic busy();
    logic b = 1'b0;
    for (int i = 0; i < 4; i++) if (rem[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i] = rem[i] > 0;
      s_tlast[i] = beat[i] == len[i] - 1;
      s_tdrop[i] = beat[i] == drop_at[i];
      s_tdata[i*8 +: 8] = {2'(i), 2'(pkt[i]), 4'(beat[i])};
    end
    m_tready = rdy;
  endtask

  // one cycle: drive at negedge, observe mid-cycle, advance the source model on fires
  task automatic cyc();
    @(negedge clk);
    drive();
    #1;
    if (m_tvalid && m_tready) begin
      log_d.push_back(m_tdata);
      log_l.push_back(m_tlast);
      log_c.push_back(cyc_n);
    end
    if (trunc_o) ntrunc++;
    for (int i = 0; i < 4; i++)
      if (s_tvalid[i] && s_tready[i]) begin
        if (s_tlast[i] || s_tdrop[i]) begin
          beat[i] = 0;
          pkt[i]++;
          rem[i]--;
        end else beat[i]++;
      end
    cyc_n++;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(busy()), 0);
  endtask

  task automatic clr_model();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; len[i] = 2; beat[i] = 0; pkt[i] = 0; drop_at[i] = -1;
    end
    log_d.delete(); log_l.delete(); log_c.delete();
    ntrunc = 0;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    clr_model();
    drive();
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bexp[6] = '{0, 1, 1, 2, 2, 3};
    logic rpat[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    nchk = 0; nerr = 0; cyc_n = 0;
    rst = 1'b1; rdy = 1'b1;
    clr_model();
    rem[0] = 1; rem[2] = 1;
    drive();
    // reset state
    cyc();
    chk("rst_grant", 32'(grant_o), 3);
    chk("rst_mvalid", 32'(m_tvalid), 0);
    chk("rst_sready", 32'(s_tready), 0);
    chk("rst_mlast", 32'(m_tlast), 0);
    chk("rst_mdrop", 32'(m_tdrop), 0);
    chk("rst_trunc", 32'(trunc_o), 0);
    rst = 1'b0;
    #1 chk("idle_bubble", 32'(m_tvalid), 0);
    cyc();
    chk("first_grant", 32'(grant_o), 0);
    chk("first_mvalid", 32'(m_tvalid), 1);
    chk("first_sready", 32'(s_tready), 4'b0001);
    drain(20);

    // round robin, 2-beat packets
    rst_pulse();
    rem = '{2, 1, 1, 1};
    drain(40);
    chk("rr_beats", 32'(log_d.size()), 10);
    for (int k = 0; k < 5 && 2*k+1 < log_d.size(); k++) begin
      chk("rr_b0", 32'(log_d[2*k]), {24'd0, 2'(k % 4), 2'(k / 4), 4'd0});
      chk("rr_b1", 32'(log_d[2*k+1]), {24'd0, 2'(k % 4), 2'(k / 4), 4'd1});
      chk("rr_last", 32'({log_l[2*k], log_l[2*k+1]}), 2'b01);
      chk("rr_gap", 32'(log_c[2*k+1] - log_c[2*k]), 1);
      chk("rr_period", 32'(log_c[2*k] - log_c[0]), 32'(3*k));
    end

    // backpressure on a 4-beat packet from port 0 while others wait
    rst_pulse();
    rem = '{1, 1, 1, 1};
    len[0] = 4;
    cyc();
    chk("bp_idle", 32'(m_tvalid), 0);
    for (int j = 0; j < 6; j++) begin
      rdy = rpat[j];
      cyc();
      chk("bp_others", 32'(s_tready & 4'b1110), 0);
      chk("bp_sready", 32'(s_tready[0]), 32'(rpat[j]));
      chk("bp_valid", 32'(m_tvalid), 1);
      chk("bp_data", 32'(m_tdata), {24'd0, 2'd0, 2'd0, 4'(bexp[j])});
    end
    rdy = 1'b1;
    drain(30);

    // watchdog truncates a 7-beat packet on beat 4
    rst_pulse();
    rem[2] = 1; len[2] = 7;
    cyc();
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk("wd_grant", 32'(grant_o), 2);
      chk("wd_mvalid", 32'(m_tvalid), 32'(k <= 4));
      chk("wd_mdrop", 32'(m_tdrop), 32'(k == 4));
      chk("wd_mlast", 32'(m_tlast), 32'(k == 7 && k <= 4));
      chk("wd_trunc", 32'(trunc_o), 32'(k == 5));
      chk("wd_sready", 32'(s_tready), 4'b0100);
    end
    cyc();
    chk("wd_idle", 32'({m_tvalid, s_tready}), 0);
    chk("wd_pulses", 32'(ntrunc), 1);
    chk("wd_fifo_beats", 32'(log_d.size()), 4);

    // last on beat MAXLEN wins over the watchdog
    ntrunc = 0;
    rem[3] = 1; len[3] = 4;
    for (int k = 0; k < 5; k++) cyc();
    chk("lim_mvalid", 32'(m_tvalid), 1);
    chk("lim_mlast", 32'(m_tlast), 1);
    chk("lim_mdrop", 32'(m_tdrop), 0);
    cyc();
    chk("lim_trunc", 32'(trunc_o), 0);
    chk("lim_idle", 32'(m_tvalid), 0);
    chk("lim_pulses", 32'(ntrunc), 0);

    // source drop on beat 2 is forwarded and arbitration moves on
    rem[0] = 1; len[0] = 4; drop_at[0] = 1;
    rem[1] = 1; len[1] = 2;
    for (int k = 0; k < 3; k++) cyc();
    chk("drop_mdrop", 32'(m_tdrop), 1);
    chk("drop_mvalid", 32'(m_tvalid), 1);
    chk("drop_mlast", 32'(m_tlast), 0);
    cyc();
    chk("drop_bubble", 32'(m_tvalid), 0);
    cyc();
    chk("drop_next_grant", 32'(grant_o), 1);
    chk("drop_next_data", 32'(m_tdata), {24'd0, 2'd1, 2'd0, 4'd0});
    drain(20);

    // async reset during BUSY beat 3
    rst_pulse();
    rem[1] = 1; len[1] = 6;
    for (int k = 0; k < 3; k++) cyc();
    @(negedge clk);
    drive();
    #1;
    chk("ar_pre_valid", 32'(m_tvalid), 1);
    chk("ar_pre_data", 32'(m_tdata), {24'd0, 2'd1, 2'd0, 4'd2});
    rst = 1'b1;
    #1;
    chk("ar_mvalid", 32'(m_tvalid), 0);
    chk("ar_sready", 32'(s_tready), 0);
    chk("ar_mlast_drop", 32'({m_tlast, m_tdrop}), 0);
    chk("ar_grant", 32'(grant_o), 3);
    beat[1] = 0; len[1] = 2;
    rem[0] = 1; len[0] = 2;
    drive();
    rst = 1'b0;
    cyc();
    chk("ar_next_grant", 32'(grant_o), 0);
    chk("ar_next_data", 32'(m_tdata), {24'd0, 2'd0, 2'd0, 4'd0});
    drain(20);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
